// File: rtl/requant_rr_scheduler_if.sv
// requant_rr_scheduler_if: request, requant-pipeline and result signals of the round-robin requant scheduler
//  req_valid/req_ready/req_x/req_qmul/req_shift : per-requester request lanes (32-bit slice i = requester i)
//  mq_valid/mq_x/mq_qmul/mq_shift               : issue side towards the requant pipeline
//  mq_out_valid/mq_result                       : return side from the requant pipeline
//  res_valid/res_ready/res_data/res_id          : tagged result stream
//  slave  = scheduler view, master = surrounding requesters, pipeline and consumer
interface requant_rr_scheduler_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [32*NUM_REQ-1:0] req_x;
  logic [32*NUM_REQ-1:0] req_qmul;
  logic [32*NUM_REQ-1:0] req_shift;
  logic                  mq_valid;
  logic [31:0]           mq_x;
  logic [31:0]           mq_qmul;
  logic [31:0]           mq_shift;
  logic                  mq_out_valid;
  logic [31:0]           mq_result;
  logic                  res_valid;
  logic                  res_ready;
  logic [31:0]           res_data;
  logic [ID_W-1:0]       res_id;
  modport slave (
    input  req_valid, req_x, req_qmul, req_shift, mq_out_valid, mq_result, res_ready,
    output req_ready, mq_valid, mq_x, mq_qmul, mq_shift, res_valid, res_data, res_id
  );
  modport master (
    output req_valid, req_x, req_qmul, req_shift, mq_out_valid, mq_result, res_ready,
    input  req_ready, mq_valid, mq_x, mq_qmul, mq_shift, res_valid, res_data, res_id
  );
endinterface

// File: rtl/requant_rr_scheduler.sv
// requant_rr_scheduler: round-robin sharing of one non-stallable requant pipeline with credit-based issue
//  clk          clock
//  rst          asynchronous, active-low reset
//  bus          requant_rr_scheduler_if.slave (requests, pipeline issue/return, tagged results)
//  busy         work in flight or buffered
//  tag_err      sticky: pipeline returned a result while no tag was outstanding
//  Optional REQSCHED_PERF_EN: adds stall_cycles[31:0] and grant_cnt[32*NUM_REQ-1:0] (saturating)
module requant_rr_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int MQ_LAT     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  requant_rr_scheduler_if.slave     bus,
  output logic                      busy,
  output logic                      tag_err
`ifdef REQSCHED_PERF_EN
  ,
  output logic [31:0]               stall_cycles,
  output logic [32*NUM_REQ-1:0]     grant_cnt
`endif
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW+1)'(FIFO_DEPTH);
  if (FIFO_DEPTH < MQ_LAT + 1 || ID_W != $clog2(NUM_REQ)) begin : g_cfg_err
    $error("requant_rr_scheduler: inconsistent parameters");
  end
  logic [ID_W-1:0]  rr_ptr, rr_next, gnt, idx;
  logic             found, can_issue, hs;
  logic [31:0]      sel_x, sel_qmul, sel_shift;
  logic [NUM_REQ-1:0] ready_v;
  logic [CW-1:0]    inflight, res_count, res_count_nx;
  logic [PW-1:0]    tag_wptr, tag_rptr, res_wptr, res_rptr, res_rptr_nx;
  logic [ID_W-1:0]  tag_mem [FIFO_DEPTH];
  logic [ID_W+31:0] res_mem [FIFO_DEPTH];
  logic [ID_W+31:0] wr_word, head_nx;
  logic             tag_pop, res_pop;
  // Every issue reserves one result slot until the consumer takes it, so the pipeline never overruns the FIFO.
  assign can_issue = ({1'b0, inflight} + {1'b0, res_count}) < DEPTH_C;
  always_comb begin
    found     = 1'b0;
    gnt       = '0;
    idx       = '0;
    sel_x     = '0;
    sel_qmul  = '0;
    sel_shift = '0;
    ready_v   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = ID_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        gnt   = idx;
      end
    end
    hs = found & can_issue;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt == ID_W'(i)) begin
        sel_x      = bus.req_x[32*i +: 32];
        sel_qmul   = bus.req_qmul[32*i +: 32];
        sel_shift  = bus.req_shift[32*i +: 32];
        ready_v[i] = hs;
      end
    end
  end
  assign bus.req_ready = ready_v;
  assign rr_next       = (gnt == ID_W'(NUM_REQ - 1)) ? '0 : gnt + 1'b1;
  assign tag_pop       = bus.mq_out_valid & (inflight != '0);
  assign res_pop       = bus.res_valid & bus.res_ready;
  assign wr_word       = {tag_mem[tag_rptr], bus.mq_result};
  assign res_count_nx  = res_count + CW'(tag_pop) - CW'(res_pop);
  assign res_rptr_nx   = res_rptr + PW'(res_pop);
  // The new word becomes the head when everything older is gone (or leaving this cycle).
  assign head_nx       = (tag_pop && res_count == CW'(res_pop)) ? wr_word : res_mem[res_rptr_nx];
  assign busy          = (inflight != '0) | (res_count != '0) | bus.mq_valid;
  always_ff @(posedge clk) begin
    if (hs) tag_mem[tag_wptr] <= gnt;
    if (tag_pop) res_mem[res_wptr] <= wr_word;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mq_valid  <= 1'b0;
      bus.mq_x      <= '0;
      bus.mq_qmul   <= '0;
      bus.mq_shift  <= '0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= '0;
      rr_ptr        <= '0;
      tag_wptr      <= '0;
      tag_rptr      <= '0;
      inflight      <= '0;
      res_wptr      <= '0;
      res_rptr      <= '0;
      res_count     <= '0;
      tag_err       <= 1'b0;
    end else begin
      bus.mq_valid <= hs;
      if (hs) begin
        bus.mq_x     <= sel_x;
        bus.mq_qmul  <= sel_qmul;
        bus.mq_shift <= sel_shift;
        rr_ptr       <= rr_next;
        tag_wptr     <= tag_wptr + 1'b1;
      end
      if (tag_pop) begin
        tag_rptr <= tag_rptr + 1'b1;
        res_wptr <= res_wptr + 1'b1;
      end
      inflight      <= inflight + CW'(hs) - CW'(tag_pop);
      res_rptr      <= res_rptr_nx;
      res_count     <= res_count_nx;
      bus.res_valid <= res_count_nx != '0;
      if (res_count_nx != '0) {bus.res_id, bus.res_data} <= head_nx;
      if (bus.mq_out_valid && inflight == '0) tag_err <= 1'b1;
    end
  end
`ifdef REQSCHED_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cycles <= '0;
      grant_cnt    <= '0;
    end else begin
      if ((|bus.req_valid) && !can_issue && stall_cycles != '1) stall_cycles <= stall_cycles + 1'b1;
      for (int i = 0; i < NUM_REQ; i++)
        if (hs && gnt == ID_W'(i) && grant_cnt[32*i +: 32] != '1)
          grant_cnt[32*i +: 32] <= grant_cnt[32*i +: 32] + 1'b1;
    end
  end
`endif
endmodule

// File: tb/tb_requant_rr_scheduler.sv
// tb_requant_rr_scheduler: scoreboard bench with a behavioural requant pipeline (MQ_LAT stages)
module tb_requant_rr_scheduler;
  localparam int N   = 4;
  localparam int IW  = 2;
  localparam int D   = 8;
  localparam int LAT = 5;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy, tag_err;
  always #5 clk = ~clk;
  requant_rr_scheduler_if #(.NUM_REQ(N), .ID_W(IW)) bus();
`ifdef REQSCHED_PERF_EN
  logic [31:0]     stall_cycles;
  logic [32*N-1:0] grant_cnt;
`endif
  requant_rr_scheduler #(.NUM_REQ(N), .ID_W(IW), .FIFO_DEPTH(D), .MQ_LAT(LAT)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .busy(busy),
    .tag_err(tag_err)
`ifdef REQSCHED_PERF_EN
    ,
    .stall_cycles(stall_cycles),
    .grant_cnt(grant_cnt)
`endif
  );
  // MultiplyByQuantizedMultiplier reference (SaturatingRoundingDoublingHighMul + RoundingDivideByPOT)
  function automatic logic [31:0] mbqm(input logic signed [31:0] x, input logic signed [31:0] q, input logic signed [31:0] s);
    int ls, rs, m, r, t;
    logic signed [31:0] xs, hi;
    logic signed [63:0] ab, nudge;
    ls = (s > 0) ? s : 0;
    rs = (s > 0) ? 0 : -s;
    xs = x <<< ls;
    if (xs == 32'sh80000000 && q == 32'sh80000000) hi = 32'sh7fffffff;
    else begin
      ab    = xs * q;
      nudge = (ab >= 0) ? 64'sd1073741824 : (64'sd1 - 64'sd1073741824);
      hi    = 32'((ab + nudge) / 64'sd2147483648);
    end
    m = (1 << rs) - 1;
    r = hi & m;
    t = (m >> 1) + ((hi < 0) ? 1 : 0);
    return (hi >>> rs) + ((r > t) ? 32'sd1 : 32'sd0);
  endfunction
  logic [LAT-1:0] pv;
  logic [31:0]    pr [LAT];
  logic           inj = 1'b0;
  always @(posedge clk or negedge rst) begin
    if (!rst) pv <= '0;
    else begin
      pv    <= {pv[LAT-2:0], bus.mq_valid};
      pr[0] <= mbqm(bus.mq_x, bus.mq_qmul, bus.mq_shift);
      for (int k = 1; k < LAT; k++) pr[k] <= pr[k-1];
    end
  end
  assign bus.mq_out_valid = pv[LAT-1] | inj;
  assign bus.mq_result    = inj ? 32'hdeadbeef : pr[LAT-1];
  int n_chk = 0, n_fail = 0;
  logic [IW+31:0] exp_q[$];
  int gnt_q[$];
  int rem[N];
  int hs_cnt = 0, got_cnt = 0, stall_seen = 0, cyc = 0, rdy_mode = 0;
  bit rand_data = 1'b0;
  logic [31:0] dx[N], dq[N], ds[N];
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cycle();
    logic [IW+31:0] e;
    @(negedge clk);
    for (int i = 0; i < N; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        exp_q.push_back({IW'(i), mbqm(bus.req_x[32*i +: 32], bus.req_qmul[32*i +: 32], bus.req_shift[32*i +: 32])});
        gnt_q.push_back(i);
        hs_cnt++;
        if (rem[i] > 0) rem[i]--;
      end
    if ((|bus.req_valid) && bus.req_ready == '0) stall_seen++;
    if (bus.res_valid && bus.res_ready) begin
      got_cnt++;
      if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 1);
      else begin
        e = exp_q.pop_front();
        check("res_data", bus.res_data, e[31:0]);
        check("res_id", bus.res_id, e[IW+31:32]);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = rem[i] > 0;
      if (rand_data) begin
        bus.req_x[32*i +: 32]     = $urandom_range(0, 2000000) - 1000000;
        bus.req_qmul[32*i +: 32]  = 32'h40000000 | ($urandom & 32'h3fffffff);
        bus.req_shift[32*i +: 32] = $urandom_range(0, 12) - 8;
      end else begin
        bus.req_x[32*i +: 32]     = dx[i];
        bus.req_qmul[32*i +: 32]  = dq[i];
        bus.req_shift[32*i +: 32] = ds[i];
      end
    end
    bus.res_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
  endtask
  task automatic wait_hs(input int n, input string tag);
    int h0, t;
    h0 = hs_cnt;
    t  = 0;
    while (hs_cnt - h0 < n && t < 300) begin
      cycle();
      t++;
    end
    check(tag, 64'(hs_cnt - h0), 64'(n));
  endtask
  task automatic drain(input string tag);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || bus.res_valid) && t < 3000) begin
      cycle();
      t++;
    end
    check(tag, 64'(exp_q.size()), 0);
  endtask
  task automatic do_reset();
    rst = 1'b0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    exp_q.delete();
    gnt_q.delete();
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int t, t0, g0, h1;
    bus.req_valid = '0;
    bus.req_x     = '0;
    bus.req_qmul  = '0;
    bus.req_shift = '0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      rem[i] = 0;
      dx[i]  = '0;
      dq[i]  = '0;
      ds[i]  = '0;
    end
    #2 rst = 1'b0;
    #1;
    check("rst_mq_valid", bus.mq_valid, 0);
    check("rst_mq_x", bus.mq_x, 0);
    check("rst_res_valid", bus.res_valid, 0);
    check("rst_res_data", bus.res_data, 0);
    check("rst_res_id", bus.res_id, 0);
    check("rst_busy", busy, 0);
    check("rst_tag_err", tag_err, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    // single request with known result
    dx[0] = 32'd100; dq[0] = 32'h40000000; ds[0] = 32'd0; rem[0] = 1;
    wait_hs(1, "t1_issue");
    t0 = cyc - 1;
    check("t1_mq_valid", bus.mq_valid, 1);
    check("t1_mq_x", bus.mq_x, 100);
    check("t1_mq_qmul", bus.mq_qmul, 64'h40000000);
    check("t1_mq_shift", bus.mq_shift, 0);
    check("t1_busy", busy, 1);
    t = 0;
    while (!bus.res_valid && t < 50) begin
      cycle();
      t++;
    end
    check("t1_latency", 64'(cyc - t0), 64'(LAT + 2));
    check("t1_data", bus.res_data, 50);
    check("t1_id", bus.res_id, 0);
    drain("t1_drain");
    check("t1_idle", busy, 0);
    // fairness
    do_reset();
    rand_data = 1'b1;
    for (int i = 0; i < N; i++) rem[i] = 2;
    wait_hs(8, "t2_issue");
    check("t2_count", 64'(gnt_q.size()), 8);
    for (int k = 0; k < gnt_q.size() && k < 8; k++) check("t2_order", 64'(gnt_q[k]), 64'(k % N));
    drain("t2_drain");
    // backpressure fills exactly the credit budget
    rdy_mode = 1;
    g0 = hs_cnt;
    for (int i = 0; i < N; i++) rem[i] = 100;
    repeat (30) cycle();
    check("t3_issues", 64'(hs_cnt - g0), 64'(D));
    check("t3_ready", bus.req_ready, 0);
    check("t3_busy", busy, 1);
    check("t3_res_valid", bus.res_valid, 1);
    rdy_mode = 0;
    g0 = got_cnt;
    t  = 0;
    while (got_cnt - g0 < D && t < 60) begin
      cycle();
      t++;
    end
    check("t3_drained", 64'(got_cnt - g0), 64'(D));
    h1 = hs_cnt;
    repeat (10) cycle();
    check("t3_resume", 64'(hs_cnt > h1), 1);
    for (int i = 0; i < N; i++) rem[i] = 0;
    drain("t3_drain");
    // random consumer readiness around a full FIFO
    rdy_mode   = 2;
    g0         = got_cnt;
    stall_seen = 0;
    for (int i = 0; i < N; i++) rem[i] = 16;
    t = 0;
    while ((got_cnt - g0 < 64 || exp_q.size() != 0) && t < 3000) begin
      cycle();
      t++;
    end
    check("t4_count", 64'(got_cnt - g0), 64);
    check("t4_sb_empty", 64'(exp_q.size()), 0);
    check("t4_full_seen", 64'(stall_seen > 0), 1);
    rdy_mode = 0;
    drain("t4_drain");
    // reset with three requests in flight
    rem[0] = 3;
    wait_hs(3, "t5_issue");
    check("t5_busy_pre", busy, 1);
    #2 rst = 1'b0;
    #1;
    check("t5_mq_valid", bus.mq_valid, 0);
    check("t5_mq_x", bus.mq_x, 0);
    check("t5_res_valid", bus.res_valid, 0);
    check("t5_res_data", bus.res_data, 0);
    check("t5_busy", busy, 0);
    exp_q.delete();
    for (int i = 0; i < N; i++) rem[i] = 0;
    bus.req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    rand_data = 1'b0;
    dx[1] = 32'(-7777); dq[1] = 32'h5a000000; ds[1] = 32'(-3); rem[1] = 1;
    g0 = got_cnt;
    wait_hs(1, "t5_new_issue");
    drain("t5_drain");
    check("t5_new_result", 64'(got_cnt - g0), 1);
    check("t5_tag_err", tag_err, 0);
    // spurious pipeline output with no outstanding tag
    inj = 1'b1;
    cycle();
    inj = 1'b0;
    check("t6_tag_err", tag_err, 1);
    check("t6_res_valid", bus.res_valid, 0);
    repeat (5) cycle();
    check("t6_tag_err_sticky", tag_err, 1);
    check("t6_res_valid_later", bus.res_valid, 0);
    check("t6_busy", busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
